// File: rtl/sr_pkg.sv
// Shared types and constants for the SR command sequencer.
// Imported by the sequencer top and its pulse timer.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } sr_state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_RST = 1'b0;

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable 4-bit down-counter; holds at zero and
// flags it for the sequencer state machine.
module sr_pulse_timer
  import sr_pkg::*;
(
  input  logic       clock,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/sr_cmd_seq.sv
// Turns set/reset commands into timed pulses for a
// downstream SR stage, suppressing redundant ones.
module sr_cmd_seq
  import sr_pkg::*;
#(
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       cmd_valid,
  input  logic       cmd_op,
  output logic       cmd_ready,
  output logic       set,
  output logic       reset,
  output logic       busy,
  output logic       exp_q,
  output logic       exp_valid,
  output logic [7:0] redund_cnt
);

  localparam bit HAS_GAP = (GAP_CYC > 0);
  localparam logic [3:0] PLD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] GLD =
    HAS_GAP ? 4'(GAP_CYC - 1) : 4'd0;

  sr_state_t  state;
  logic       op_q;
  logic       accept;
  logic       redundant;
  logic       start;
  logic       pulse_end;
  logic       tmr_load;
  logic [3:0] tmr_val;
  logic       tmr_zero;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign redundant = exp_valid & (cmd_op == exp_q);
  assign start     = accept & ~redundant;
  assign pulse_end = (state == PULSE) & tmr_zero;

  // Timer counts down to zero: load N-1 for N cycles.
  assign tmr_load = start | (pulse_end & HAS_GAP);
  assign tmr_val  = start ? PLD : GLD;

  sr_pulse_timer u_timer (
    .clock    (clock),
    .clear    (clear),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state      <= IDLE;
      op_q       <= 1'b0;
      set        <= 1'b0;
      reset      <= 1'b0;
      busy       <= 1'b0;
      exp_q      <= 1'b0;
      exp_valid  <= 1'b0;
      redund_cnt <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && redundant) begin
            if (redund_cnt != 8'hff) begin
              redund_cnt <= redund_cnt + 8'd1;
            end
          end else if (start) begin
            state <= PULSE;
            op_q  <= cmd_op;
            set   <= (cmd_op == OP_SET);
            reset <= (cmd_op == OP_RST);
            busy  <= 1'b1;
          end
        end
        PULSE: begin
          if (tmr_zero) begin
            set       <= 1'b0;
            reset     <= 1'b0;
            exp_q     <= op_q;
            exp_valid <= 1'b1;
            if (HAS_GAP) begin
              state <= GAP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        GAP: begin
          if (tmr_zero) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          set   <= 1'b0;
          reset <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_cmd_seq.sv
// Bench for sr_cmd_seq: two instances (2/1 and 1/0
// timing) checked each cycle against an age-based model.
module tb_sr_cmd_seq;

  logic       clock;
  logic       clear;
  logic       valid [2];
  logic       op    [2];
  logic       rdy   [2];
  logic       set_s [2];
  logic       rst_s [2];
  logic       bsy   [2];
  logic       eq    [2];
  logic       ev    [2];
  logic [7:0] cnt   [2];

  int n_cmp = 0;
  int n_bad = 0;
  int n_cycle = 0;

  int   m_age [2];
  logic m_op  [2];
  logic m_eq  [2];
  logic m_ev  [2];
  int   m_cnt [2];
  bit   m_acc [2];

  sr_cmd_seq #(.PULSE_CYC(2), .GAP_CYC(1)) dut0 (
    .clock(clock), .clear(clear),
    .cmd_valid(valid[0]), .cmd_op(op[0]),
    .cmd_ready(rdy[0]), .set(set_s[0]),
    .reset(rst_s[0]), .busy(bsy[0]),
    .exp_q(eq[0]), .exp_valid(ev[0]),
    .redund_cnt(cnt[0])
  );

  sr_cmd_seq #(.PULSE_CYC(1), .GAP_CYC(0)) dut1 (
    .clock(clock), .clear(clear),
    .cmd_valid(valid[1]), .cmd_op(op[1]),
    .cmd_ready(rdy[1]), .set(set_s[1]),
    .reset(rst_s[1]), .busy(bsy[1]),
    .exp_q(eq[1]), .exp_valid(ev[1]),
    .redund_cnt(cnt[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int pc(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int gc(int i);
    return (i == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input int i,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[%0d]: got %0h want %0h",
             tag, i, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_age[i] = -1;
      m_op[i]  = 1'b0;
      m_eq[i]  = 1'b0;
      m_ev[i]  = 1'b0;
      m_cnt[i] = 0;
      m_acc[i] = 1'b0;
    end
  endtask

  // age = cycles since the accepting edge; -1 when idle
  task automatic model_step(input int i);
    m_acc[i] = 1'b0;
    if (m_age[i] < 0) begin
      if (valid[i]) begin
        if (m_ev[i] && op[i] == m_eq[i]) begin
          if (m_cnt[i] < 255) m_cnt[i]++;
        end else begin
          m_age[i] = 0;
          m_op[i]  = op[i];
          m_acc[i] = 1'b1;
        end
      end
    end else begin
      m_age[i]++;
      if (m_age[i] == pc(i)) begin
        m_eq[i] = m_op[i];
        m_ev[i] = 1'b1;
      end
      if (m_age[i] == pc(i) + gc(i)) m_age[i] = -1;
    end
  endtask

  task automatic check_all(input int i);
    bit b, pl;
    b  = (m_age[i] >= 0);
    pl = b && (m_age[i] < pc(i));
    chk("cmd_ready", i, 8'(rdy[i]), 8'(!b));
    chk("busy", i, 8'(bsy[i]), 8'(b));
    chk("set", i, 8'(set_s[i]), 8'(pl && m_op[i]));
    chk("reset", i, 8'(rst_s[i]), 8'(pl && !m_op[i]));
    chk("overlap", i, 8'(set_s[i] & rst_s[i]), 8'd0);
    chk("exp_q", i, 8'(eq[i]), 8'(m_eq[i]));
    chk("exp_valid", i, 8'(ev[i]), 8'(m_ev[i]));
    chk("redund_cnt", i, cnt[i], 8'(m_cnt[i]));
  endtask

  task automatic step();
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
    check_all(0);
    check_all(1);
    n_cycle++;
  endtask

  // Called just after a step; clear low/high between edges.
  task automatic do_clear();
    #2;
    clear = 1'b0;
    #1;
    model_reset();
    check_all(0);
    check_all(1);
    #2;
    clear = 1'b1;
  endtask

  task automatic wait_idle();
    valid[0] = 1'b0;
    valid[1] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (m_age[0] < 0 && m_age[1] < 0) break;
      step();
    end
  endtask

  task automatic issue(input int i, input logic o);
    valid[i] = 1'b1;
    op[i]    = o;
    step();
    valid[i] = 1'b0;
    wait_idle();
  endtask

  initial begin
    int sc, bc, last;
    logic prev;
    clear = 1'b1;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0;
      op[i]    = 1'b0;
    end
    model_reset();
    #1;
    do_clear();
    step();

    // single set command: 2 set cycles, 3 busy cycles
    valid[0] = 1'b1;
    op[0]    = 1'b1;
    step();
    valid[0] = 1'b0;
    sc = int'(set_s[0]);
    bc = int'(bsy[0]);
    for (int k = 0; k < 5; k++) begin
      step();
      sc += int'(set_s[0]);
      bc += int'(bsy[0]);
    end
    chk("set_cycles", 0, 8'(sc), 8'd2);
    chk("busy_cycles", 0, 8'(bc), 8'd3);
    chk("exp_q_after", 0, 8'(eq[0]), 8'd1);
    chk("exp_valid_after", 0, 8'(ev[0]), 8'd1);

    // three redundant set commands
    valid[0] = 1'b1;
    op[0]    = 1'b1;
    for (int k = 0; k < 3; k++) step();
    valid[0] = 1'b0;
    chk("redund3", 0, cnt[0], 8'd3);
    chk("ready_redund", 0, 8'(rdy[0]), 8'd1);

    // held valid, alternating op: accepts every 4 cycles
    valid[0] = 1'b1;
    op[0]    = 1'b0;
    last = -1;
    for (int k = 0; k < 20; k++) begin
      prev = bsy[0];
      step();
      if (m_acc[0]) op[0] = ~op[0];
      if (bsy[0] && !prev) begin
        if (last >= 0)
          chk("spacing0", 0, 8'(n_cycle - last), 8'd4);
        last = n_cycle;
      end
    end
    wait_idle();

    // clear during the second set cycle
    if (m_ev[0] && m_eq[0]) issue(0, 1'b0);
    valid[0] = 1'b1;
    op[0]    = 1'b1;
    step();
    valid[0] = 1'b0;
    step();
    chk("set_pre_clear", 0, 8'(set_s[0]), 8'd1);
    do_clear();
    step();
    chk("ready_post_clear", 0, 8'(rdy[0]), 8'd1);
    valid[0] = 1'b1;
    op[0]    = 1'b0;
    step();
    valid[0] = 1'b0;
    chk("rst_not_redund", 0, 8'(rst_s[0]), 8'd1);
    wait_idle();

    // PULSE_CYC=1, GAP_CYC=0: accepts every 2 cycles
    valid[1] = 1'b1;
    op[1]    = 1'b1;
    last = -1;
    for (int k = 0; k < 12; k++) begin
      prev = bsy[1];
      step();
      if (m_acc[1]) op[1] = ~op[1];
      if (bsy[1] && !prev) begin
        if (last >= 0)
          chk("spacing1", 1, 8'(n_cycle - last), 8'd2);
        last = n_cycle;
      end
    end
    wait_idle();

    // random traffic on both instances
    for (int k = 0; k < 300; k++) begin
      valid[0] = 1'($urandom_range(0, 1));
      op[0]    = 1'($urandom_range(0, 1));
      valid[1] = 1'($urandom_range(0, 1));
      op[1]    = 1'($urandom_range(0, 1));
      step();
    end
    wait_idle();

    // counter saturation after 260 redundant commands
    do_clear();
    step();
    issue(0, 1'b1);
    valid[0] = 1'b1;
    op[0]    = 1'b1;
    for (int k = 0; k < 260; k++) step();
    valid[0] = 1'b0;
    step();
    chk("redund_sat", 0, cnt[0], 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
